// File: rtl/add_int32_operand_stager.sv
// -----------------------------------------------------------------------------
// add_int32_operand_stager
//   Pairs a word-serial operand stream into (A, B) pairs for the 32-bit adder.
//   Even-indexed accepted words are A and odd-indexed ones are B. Each complete
//   pair is pushed into a small FIFO, and the FIFO head is presented to the adder.
//   A half-formed pair never reaches the output.
//
// Optional feature: define ADD_STAGER_STATS_EN to add the pairs_issued counter port.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   word handshake from the producer
//   in_data             operand word
//   flush               synchronous drop of the pending A and all buffered pairs
//   out_valid/out_ready pair handshake to the adder
//   out_a, out_b        head pair (0 when out_valid is low)
//   count               pairs currently buffered
//   a_pending           an A word is held, waiting for its B
//   pairs_issued        (stats only) pops since reset/flush, wraps at 2^32
// -----------------------------------------------------------------------------
module add_int32_operand_stager #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b,
  output logic [$clog2(DEPTH):0]   count,
`ifdef ADD_STAGER_STATS_EN
  output logic [31:0]              pairs_issued,
`endif
  output logic                     a_pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {WAIT_A = 1'b0, WAIT_B = 1'b1} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  pair_t            mem_q [DEPTH];

  logic accept, push, pop;

  // in_ready depends only on registered state, so the producer never sees
  // a combinational path from out_ready.
  assign in_ready  = (state_q == WAIT_A) || (count_q < CW'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready && !flush;
  // A word accepted in a flush cycle is discarded, so it never pushes.
  assign push      = accept && (state_q == WAIT_B) && !flush;

  assign out_a     = out_valid ? mem_q[rd_ptr_q].a : '0;
  assign out_b     = out_valid ? mem_q[rd_ptr_q].b : '0;
  assign count     = count_q;
  assign a_pending = (state_q == WAIT_B);

  // Pairing FSM and holding register for A.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    if (flush) begin
      state_d = WAIT_A;
    end else if (accept) begin
      if (state_q == WAIT_A) begin
        a_d     = in_data;
        state_d = WAIT_B;
      end else begin
        state_d = WAIT_A;
      end
    end
  end

  // Pointers wrap naturally at AW bits because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_A;
      a_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: stale entries are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{a: a_q, b: in_data};
  end

`ifdef ADD_STAGER_STATS_EN
  logic [31:0] pairs_issued_q, pairs_issued_d;

  always_comb begin
    pairs_issued_d = pairs_issued_q;
    if (flush)    pairs_issued_d = '0;
    else if (pop) pairs_issued_d = pairs_issued_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pairs_issued_q <= '0;
    else        pairs_issued_q <= pairs_issued_d;
  end

  assign pairs_issued = pairs_issued_q;
`endif

endmodule

// File: tb/tb_add_int32_operand_stager.sv
// -----------------------------------------------------------------------------
// Directed testbench for add_int32_operand_stager (WIDTH=32, DEPTH=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_add_int32_operand_stager;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a, out_b;
  logic [2:0]  count;
  logic        a_pending;
`ifdef ADD_STAGER_STATS_EN
  logic [31:0] pairs_issued;
`endif

  int checks = 0;
  int errors = 0;

  add_int32_operand_stager #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .count(count),
`ifdef ADD_STAGER_STATS_EN
    .pairs_issued(pairs_issued),
`endif
    .a_pending(a_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    in_valid = 0; in_data = '0; flush = 0; out_ready = 0;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  // Push words lo..hi with out_ready low; each must be accepted immediately.
  task automatic push_words(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      in_valid = 1; in_data = 32'(i);
      tick();
    end
    in_valid = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_a !== 32'd0 || out_b !== 32'd0) begin errors++; $display("FAIL reset_out_ab: got %h/%h want 0/0", out_a, out_b); end
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (a_pending !== 1'b0) begin errors++; $display("FAIL reset_a_pending: got %b want 0", a_pending); end
`ifdef ADD_STAGER_STATS_EN
    checks++; if (pairs_issued !== 32'd0) begin errors++; $display("FAIL reset_pairs_issued: got %0d want 0", pairs_issued); end
`endif
  endtask

  task automatic test_basic_pair();
    apply_reset();
    out_ready = 1; in_valid = 1; in_data = 32'h5;
    tick();
    checks++; if (a_pending !== 1'b1) begin errors++; $display("FAIL basic_a_pending_between: got %b want 1", a_pending); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_no_half_pair: got %b want 0", out_valid); end
    in_data = 32'hA;
    tick();
    in_valid = 0;
    checks++; if (a_pending !== 1'b0) begin errors++; $display("FAIL basic_a_pending_after: got %b want 0", a_pending); end
    checks++; if (out_valid !== 1'b1 || out_a !== 32'h5 || out_b !== 32'hA)
      begin errors++; $display("FAIL basic_pair: got v=%b a=%h b=%h want v=1 a=5 b=a", out_valid, out_a, out_b); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_a !== 32'h0) begin errors++; $display("FAIL basic_pulse_end: got v=%b a=%h want v=0 a=0", out_valid, out_a); end
`ifdef ADD_STAGER_STATS_EN
    checks++; if (pairs_issued !== 32'd1) begin errors++; $display("FAIL basic_pairs_issued: got %0d want 1", pairs_issued); end
`endif
    out_ready = 0;
  endtask

  task automatic test_fill_full();
    apply_reset();
    push_words(1, 8);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_for_a: got %b want 1", in_ready); end
    in_valid = 1; in_data = 32'd9;
    tick();
    checks++; if (a_pending !== 1'b1 || in_ready !== 1'b0)
      begin errors++; $display("FAIL fill_9th: got a_pending=%b in_ready=%b want 1/0", a_pending, in_ready); end
    in_data = 32'd10;
    tick();
    checks++; if (in_ready !== 1'b0 || count !== 3'd4)
      begin errors++; $display("FAIL fill_10th_blocked: got in_ready=%b count=%0d want 0/4", in_ready, count); end
    out_ready = 1;
    checks++; if (out_a !== 32'd1 || out_b !== 32'd2) begin errors++; $display("FAIL fill_head: got %0d/%0d want 1/2", out_a, out_b); end
    tick();
    out_ready = 0;
    checks++; if (count !== 3'd3 || in_ready !== 1'b1)
      begin errors++; $display("FAIL fill_after_pop: got count=%0d in_ready=%b want 3/1", count, in_ready); end
    tick();
    in_valid = 0;
    checks++; if (count !== 3'd4 || a_pending !== 1'b0 || out_a !== 32'd3)
      begin errors++; $display("FAIL fill_10th_taken: got count=%0d a_pending=%b head_a=%0d want 4/0/3", count, a_pending, out_a); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    push_words(1, 8);
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1 || out_a !== 32'(2*k+1) || out_b !== 32'(2*k+2) || count !== 3'(4-k))
        begin errors++; $display("FAIL drain_pair%0d: got v=%b %0d/%0d count=%0d want 1 %0d/%0d count=%0d",
                                 k, out_valid, out_a, out_b, count, 2*k+1, 2*k+2, 4-k); end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL drain_empty: got v=%b count=%0d want 0/0", out_valid, count); end
    out_ready = 0;
  endtask

  task automatic test_wrap();
    int sent = 0, got = 0, cyc = 0, peak = 0;
    apply_reset();
    while (got < 20 && cyc < 400) begin
      out_ready = cyc[0];
      in_valid  = (sent < 40);
      in_data   = 32'h1000_0000 + 32'(sent) * 32'd7;
      if (int'(count) > peak) peak = int'(count);
      if (out_valid && out_ready) begin
        checks++;
        if (out_a !== 32'h1000_0000 + 32'(2*got) * 32'd7 || out_b !== 32'h1000_0000 + 32'(2*got+1) * 32'd7)
          begin errors++; $display("FAIL wrap_pair%0d: got %h/%h want %h/%h", got, out_a, out_b,
                                   32'h1000_0000 + 32'(2*got) * 32'd7, 32'h1000_0000 + 32'(2*got+1) * 32'd7); end
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid = 0; out_ready = 0;
    checks++; if (got !== 20) begin errors++; $display("FAIL wrap_timeout: got %0d pairs want 20", got); end
    checks++; if (peak > 4) begin errors++; $display("FAIL wrap_peak_count: got %0d want <=4", peak); end
  endtask

  task automatic test_flush();
    apply_reset();
    push_words(1, 7);
    checks++; if (count !== 3'd3 || a_pending !== 1'b1)
      begin errors++; $display("FAIL flush_setup: got count=%0d a_pending=%b want 3/1", count, a_pending); end
    flush = 1; in_valid = 1; in_data = 32'h77; out_ready = 1;
    tick();
    flush = 0; in_valid = 0; out_ready = 0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || a_pending !== 1'b0 || out_a !== 32'd0)
      begin errors++; $display("FAIL flush_clear: got count=%0d v=%b a_pending=%b a=%h want 0/0/0/0", count, out_valid, a_pending, out_a); end
    push_words(32'h21, 32'h22);
    checks++; if (out_valid !== 1'b1 || out_a !== 32'h21 || out_b !== 32'h22 || count !== 3'd1)
      begin errors++; $display("FAIL flush_fresh_pair: got v=%b %h/%h count=%0d want 1 21/22 1", out_valid, out_a, out_b, count); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    push_words(1, 4);
    out_ready = 1;
    tick();
    out_ready = 0;
    push_words(5, 5);
    checks++; if (count !== 3'd1 || a_pending !== 1'b1)
      begin errors++; $display("FAIL areset_setup: got count=%0d a_pending=%b want 1/1", count, a_pending); end
    #2 rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 3'd0 || a_pending !== 1'b0 || in_ready !== 1'b1 || out_a !== 32'd0)
      begin errors++; $display("FAIL areset_immediate: got v=%b count=%0d a_pending=%b in_ready=%b a=%h want 0/0/0/1/0",
                               out_valid, count, a_pending, in_ready, out_a); end
`ifdef ADD_STAGER_STATS_EN
    checks++; if (pairs_issued !== 32'd0) begin errors++; $display("FAIL areset_pairs_issued: got %0d want 0", pairs_issued); end
`endif
    #2 rst_n = 1;
    tick();
    push_words(32'h31, 32'h32);
    out_ready = 1;
    checks++; if (out_a !== 32'h31 || out_b !== 32'h32) begin errors++; $display("FAIL areset_new_pair: got %h/%h want 31/32", out_a, out_b); end
    tick();
    out_ready = 0;
`ifdef ADD_STAGER_STATS_EN
    checks++; if (pairs_issued !== 32'd1) begin errors++; $display("FAIL areset_pairs_after_pop: got %0d want 1", pairs_issued); end
`endif
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_drained: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_fill_full();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_int32_operand_stager.md
# add_int32_operand_stager

Upstream operand stager for the 32-bit ripple adder stage. Accepts a single-word input stream with a valid/ready handshake, pairs consecutive words into (A, B) operands, and buffers complete pairs in a small FIFO. It presents one pair per cycle to the adder through a registered valid/ready interface. It decouples the word-serial producer from the adder datapath and never issues a half-formed pair.

## Interface
- WIDTH, 32, operand width in bits; the adder stage consumes 32
- DEPTH, 4, pair FIFO depth in entries; power of two, ≥ 2
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  stager accepts in_data this cycle
- in_data  input  WIDTH  operand word; even-indexed words are A, odd-indexed words are B
- flush  input  1  synchronous drop of the pending A and all FIFO contents
- out_valid  output  1  out_a/out_b hold a complete pair
- out_ready  input  1  adder stage takes the pair this cycle
- out_a  output  WIDTH  A operand of the head pair
- out_b  output  WIDTH  B operand of the head pair
- count  output  $clog2(DEPTH)+1  pairs currently buffered
- a_pending  output  1  an A word is latched and waiting for its B

## Operation
- Word accept on in_valid && in_ready; pair pop on out_valid && out_ready.
- Two-state pairing FSM:
  - WAIT_A: an accepted word goes to the A holding register; next state is WAIT_B.
  - WAIT_B: an accepted word is pushed with the held A as {A, B} into the FIFO; next state is WAIT_A.
- in_ready = (state == WAIT_A) || (count < DEPTH). Registered terms only; there is no combinational path from out_ready.
- An A word is always accepted. A B word is accepted only when a FIFO slot exists at the start of the cycle.
- out_valid = (count != 0). out_a/out_b come from the head entry and are 0 when out_valid = 0.
- Simultaneous push and pop when full: not possible, because in_ready is low in WAIT_B at count == DEPTH.
- Simultaneous push and pop otherwise: both occur and count is unchanged.
- Head data holds stable while out_valid && !out_ready.
- Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. count is a separate register, so full and empty are unambiguous.
- flush has priority over any same-cycle accept or pop:
  - the FSM returns to WAIT_A and a_pending clears;
  - count, pointers and pairs_issued (if enabled) clear to 0;
  - in_ready is unchanged combinationally that cycle; an accepted word in the flush cycle is discarded.
- Reset mid-operation discards all state immediately; no partial pair survives.
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - out_a = out_b = 0
  - count = 0
  - a_pending = 0
  - FSM in WAIT_A
  - storage contents are don't-care, masked by out_valid

## Timing
- Latency: B accepted at edge k causes out_valid = 1 in the cycle after edge k (1 cycle), when the FIFO was empty.
- Input throughput: one word per cycle, so one pair per 2 cycles. Output throughput: one pair per cycle while draining.
- Full FIFO: in_ready drops in WAIT_B only. After a pop at edge k, in_ready rises in the cycle after edge k.
- flush asserted at edge k: out_valid = 0 and a_pending = 0 in the cycle after edge k.

## Configuration
- ADD_STAGER_STATS_EN defined:
  - adds output pairs_issued [31:0], incremented on each pop;
  - wraps from 0xFFFFFFFF to 0;
  - clears on reset and on flush.
- ADD_STAGER_STATS_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then words 0x00000005 and 0x0000000A with out_ready = 1:
  - out_valid pulses for 1 cycle with out_a = 0x5, out_b = 0xA;
  - a_pending is 1 for exactly one cycle between the two words.
- Fill to full with out_ready = 0 and DEPTH = 4:
  - push 8 words 1..8; count = 4;
  - a 9th word is accepted (a_pending = 1), but in_ready stays 0 for the 10th;
  - raise out_ready for 1 cycle: the pair (1,2) pops and the 10th word is accepted next cycle.
- Back-to-back drain of 4 buffered pairs, then out_ready = 1 with in_valid = 0: pairs (1,2), (3,4), (5,6), (7,8) appear on consecutive cycles, then out_valid = 0.
- Pointer wrap: stream 20 pairs with out_ready toggling 1/0. Every pair pops in order with the correct A/B, and count never exceeds 4.
- Flush with a_pending = 1 and count = 3, in the same cycle as in_valid = 1 and out_ready = 1:
  - next cycle count = 0, out_valid = 0, a_pending = 0;
  - the next two words form a fresh pair.
- Assert rst_n = 0 asynchronously mid-stream (not edge-aligned):
  - outputs go to reset values immediately;
  - with ADD_STAGER_STATS_EN, pairs_issued = 0 and it increments after each subsequent pop.
